// File: rtl/arp_pkg.sv
// Shared definitions for the ARP request/retry controller.
// Holds the FSM state encoding and the default timing/retry constants
// used when the parent does not override the module parameters.
package arp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arp_state_e;

  localparam int ARP_TIMEOUT_TICKS = 8;  // ticks waited per attempt, >= 1
  localparam int ARP_MAX_RETRY     = 3;  // re-sends after the first attempt
  localparam int ARP_CNT_WIDTH     = 4;  // holds TIMEOUT_TICKS-1 and MAX_RETRY

endpackage

// File: rtl/arp_req_retry.sv
// ARP request/timeout/retry controller. On start it raises req_valid towards
// the ARP TX path, then waits TIMEOUT_TICKS timer ticks for a matching reply,
// re-sending up to MAX_RETRY times before reporting failure.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   tick_in               one-cycle pulse from the free-running timer
//   start, abort          begin a resolution (IDLE only) / cancel silently
//   reply_in              one-cycle pulse: matching ARP reply seen
//   req_valid, req_ready  request handshake with ARP TX (valid held until ready)
//   busy                  high in every state except IDLE
//   done, fail            one-cycle result pulses, never high together
//   attempts              retries issued so far, held after done/fail
// All outputs are registered; they reflect the state entered on each edge.
module arp_req_retry
  import arp_pkg::*;
#(
  parameter int TIMEOUT_TICKS = ARP_TIMEOUT_TICKS,
  parameter int MAX_RETRY     = ARP_MAX_RETRY,
  parameter int CNT_WIDTH     = ARP_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 reply_in,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CNT_WIDTH-1:0] attempts
);

  localparam logic [CNT_WIDTH-1:0] TICK_LAST  = CNT_WIDTH'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] RETRY_LAST = CNT_WIDTH'(MAX_RETRY);

  arp_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_WIDTH-1:0] retry_cnt_q, retry_cnt_d;
  logic                 req_valid_q, req_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;

  // Timeout of the current attempt: last tick of the window while waiting.
  // Reply has priority over a tick arriving in the same cycle.
  logic timeout_w;
  assign timeout_w = (state_q == ST_WAIT) && !reply_in && tick_in &&
                     (tick_cnt_q == TICK_LAST);

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      retry_cnt_q <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  // Next state and counters. Abort overrides everything, including a
  // handshake, tick or reply landing in the same cycle.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    retry_cnt_d = retry_cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_SEND;
            tick_cnt_d  = '0;
            retry_cnt_d = '0;
          end
        end
        ST_SEND: begin
          // req_valid_q is always high here: it is set from state_d == SEND.
          if (req_valid_q && req_ready) begin
            state_d    = ST_WAIT;
            tick_cnt_d = '0;
          end
        end
        ST_WAIT: begin
          if (reply_in) begin
            state_d = ST_IDLE;
          end else if (timeout_w) begin
            // tick_cnt stays at its last value until the next handshake clears it.
            if (retry_cnt_q == RETRY_LAST) begin
              state_d = ST_IDLE;
            end else begin
              retry_cnt_d = retry_cnt_q + 1'b1;
              state_d     = ST_SEND;
            end
          end else if (tick_in) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output next values, decoded from the state being entered.
  always_comb begin
    req_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
    done_d      = !abort && (state_q == ST_WAIT) && reply_in;
    fail_d      = !abort && timeout_w && (retry_cnt_q == RETRY_LAST);
  end

  assign req_valid = req_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign attempts  = retry_cnt_q;

endmodule

// File: tb/tb_arp_req_retry.sv
// Directed bench for arp_req_retry with default parameters
// (TIMEOUT_TICKS=8, MAX_RETRY=3, CNT_WIDTH=4).
// Expected done/fail results are queued when a scenario is launched and
// popped when the DUT pulses done or fail.
module tb_arp_req_retry;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in, start, abort, reply_in, req_ready;
  logic       req_valid, busy, done, fail;
  logic [3:0] attempts;

  typedef struct {
    logic       is_fail;
    logic [3:0] att;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  hs_cnt = 0;

  always #5 clk = ~clk;

  arp_req_retry dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .start    (start),
    .abort    (abort),
    .reply_in (reply_in),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .attempts (attempts)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample #1 after the edge. Counts real handshakes
  // and scores any done/fail pulse against the expectation queue.
  task automatic cyc();
    ev_t e;
    if (req_valid && req_ready && !abort && !reset) hs_cnt++;
    @(posedge clk);
    #1;
    if (done || fail) begin
      chk("done_fail_excl", {31'd0, done & fail}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", {30'd0, done, fail}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("evt_is_fail", {31'd0, fail}, {31'd0, e.is_fail});
        chk("evt_attempts", {28'd0, attempts}, {28'd0, e.att});
      end
    end
  endtask

  task automatic tick_gap(input int gap);
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    for (int g = 0; g < gap; g++) cyc();
  endtask

  initial begin
    int hs0;
    reset = 1'b1; tick_in = 0; start = 0; abort = 0; reply_in = 0; req_ready = 0;
    #22;
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_done",      {31'd0, done}, 32'd0);
    chk("rst_fail",      {31'd0, fail}, 32'd0);
    chk("rst_attempts",  {28'd0, attempts}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc();

    // 1: single attempt answered after three ticks
    start = 1; req_ready = 1;
    cyc();
    start = 0;
    chk("t1_req_valid_c1", {31'd0, req_valid}, 32'd1);
    chk("t1_busy_c1",      {31'd0, busy}, 32'd1);
    cyc();
    chk("t1_req_valid_c2", {31'd0, req_valid}, 32'd0);
    for (int i = 0; i < 3; i++) tick_gap(1);
    exp_q.push_back('{is_fail: 1'b0, att: 4'd0});
    reply_in = 1;
    cyc();
    reply_in = 0;
    chk("t1_done",     {31'd0, done}, 32'd1);
    chk("t1_busy",     {31'd0, busy}, 32'd0);
    chk("t1_attempts", {28'd0, attempts}, 32'd0);
    cyc();
    chk("t1_done_1cyc", {31'd0, done}, 32'd0);

    // 2: no reply -> four attempts, fail after the 32nd tick
    hs0 = hs_cnt;
    exp_q.push_back('{is_fail: 1'b1, att: 4'd3});
    start = 1;
    cyc();
    start = 0;
    cyc();
    for (int k = 1; k <= 32; k++) begin
      tick_in = 1;
      cyc();
      tick_in = 0;
      if (k >= 31) chk($sformatf("t2_fail_tick%0d", k), {31'd0, fail}, {31'd0, k == 32});
      cyc(); cyc();
    end
    chk("t2_handshakes", hs_cnt - hs0, 32'd4);
    chk("t2_attempts",   {28'd0, attempts}, 32'd3);
    chk("t2_busy",       {31'd0, busy}, 32'd0);
    reply_in = 1;
    cyc();
    reply_in = 0;
    chk("t2_late_reply_done", {31'd0, done}, 32'd0);

    // 3: req_ready withheld for 20 cycles while ticks arrive
    req_ready = 0;
    start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      tick_in = i[0];
      cyc();
      if (i == 19) chk("t3_req_valid_held", {31'd0, req_valid}, 32'd1);
      else if (req_valid !== 1'b1) chk($sformatf("t3_req_valid_c%0d", i), {31'd0, req_valid}, 32'd1);
    end
    tick_in = 0;
    req_ready = 1;
    cyc();
    chk("t3_hs_req_valid", {31'd0, req_valid}, 32'd0);
    chk("t3_hs_busy",      {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick_in = 1;
      cyc();
      tick_in = 0;
      if (k == 7) chk("t3_no_resend_7", {31'd0, req_valid}, 32'd0);
      if (k == 8) chk("t3_resend_8",    {31'd0, req_valid}, 32'd1);
      if (k < 8) begin cyc(); cyc(); end
    end
    // abort while in SEND, even with req_ready high
    abort = 1;
    cyc();
    abort = 0;
    chk("t3_abort_send_rv",   {31'd0, req_valid}, 32'd0);
    chk("t3_abort_send_busy", {31'd0, busy}, 32'd0);

    // 4: reply and last tick together -> done, not fail, no re-send
    start = 1;
    cyc();
    start = 0;
    cyc();
    for (int k = 0; k < 7; k++) tick_gap(1);
    exp_q.push_back('{is_fail: 1'b0, att: 4'd0});
    reply_in = 1; tick_in = 1;
    cyc();
    reply_in = 0; tick_in = 0;
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_fail", {31'd0, fail}, 32'd0);
    cyc();
    chk("t4_no_resend", {31'd0, req_valid}, 32'd0);
    chk("t4_idle",      {31'd0, busy}, 32'd0);

    // 5: abort in SEND, abort with reply in WAIT, start+abort in IDLE, restart
    req_ready = 0;
    start = 1;
    cyc();
    start = 0;
    abort = 1;
    cyc();
    abort = 0;
    chk("t5_abort_send_rv",   {31'd0, req_valid}, 32'd0);
    chk("t5_abort_send_busy", {31'd0, busy}, 32'd0);
    req_ready = 1;
    start = 1;
    cyc();
    start = 0;
    cyc();
    tick_gap(1);
    abort = 1; reply_in = 1;
    cyc();
    abort = 0; reply_in = 0;
    chk("t5_abort_wait_done", {31'd0, done}, 32'd0);
    chk("t5_abort_wait_busy", {31'd0, busy}, 32'd0);
    start = 1; abort = 1;
    cyc();
    start = 0; abort = 0;
    chk("t5_start_abort_busy", {31'd0, busy}, 32'd0);
    chk("t5_start_abort_rv",   {31'd0, req_valid}, 32'd0);
    exp_q.push_back('{is_fail: 1'b0, att: 4'd0});
    start = 1;
    cyc();
    start = 0;
    chk("t5_restart_rv", {31'd0, req_valid}, 32'd1);
    cyc();
    reply_in = 1;
    cyc();
    reply_in = 0;
    chk("t5_restart_done", {31'd0, done}, 32'd1);

    // 6: one retry, start while busy, then async reset mid-WAIT
    start = 1;
    cyc();
    start = 0;
    cyc();
    for (int k = 0; k < 8; k++) tick_gap(1);
    chk("t6_attempts_1", {28'd0, attempts}, 32'd1);
    start = 1;
    cyc();
    start = 0;
    chk("t6_start_busy_att",  {28'd0, attempts}, 32'd1);
    chk("t6_start_busy_rv",   {31'd0, req_valid}, 32'd0);
    chk("t6_start_busy_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1;
    #1;
    chk("t6_rst_busy",     {31'd0, busy}, 32'd0);
    chk("t6_rst_attempts", {28'd0, attempts}, 32'd0);
    chk("t6_rst_rv",       {31'd0, req_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    reply_in = 1;
    cyc();
    reply_in = 0;
    chk("t6_reply_after_rst_done", {31'd0, done}, 32'd0);
    chk("t6_reply_after_rst_busy", {31'd0, busy}, 32'd0);
    cyc();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
